spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single SPI master between two requesters: instruction fetch (ROM,
//  addressed by PC) and data access (RAM, addressed by MAR, read or write).
//  Sequences each SPI transaction (start, wait done, capture, acknowledge).
//  Drives the per-device active-low chip selects.
//  Aborts hung transactions with a watchdog.
//  Sits between the control unit/datapath and the spi module.
// PARAMETERS
//  ADDR_W   16  width of rom_addr/ram_addr/spi_addr
//  TIMEOUT  64  max cycles in BUSY waiting for spi_done before abort (>=2)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  rom_req      in   1       fetch request, level, held until rom_ack
//  rom_addr     in   ADDR_W  fetch address
//  rom_ack      out  1       1-cycle pulse: fetch done, rdata valid this cycle
//  ram_req      in   1       data request, level, held until ram_ack
//  ram_we       in   1       1=write ram_wdata, 0=read
//  ram_addr     in   ADDR_W  data address
//  ram_wdata    in   8       write data
//  ram_ack      out  1       1-cycle pulse: data access done
//  rdata        out  8       read data, held until next ack
//  spi_start    out  1       1-cycle start strobe to spi master
//  spi_write    out  1       write flag to spi master
//  spi_addr     out  ADDR_W  address to spi master, stable START..ACK
//  spi_wdata    out  8       write data to spi master, stable START..ACK
//  spi_rdata    in   8       read data from spi master
//  spi_done     in   1       completion pulse from spi master
//  cs_rom_n     out  1       ROM chip select, active-low
//  cs_ram_n     out  1       RAM chip select, active-low
//  timeout_err  out  1       sticky, set on watchdog abort, cleared only by rst
// BEHAVIOUR
//  Reset
//   - state=IDLE; all acks/spi_start/spi_write=0.
//   - cs_rom_n=cs_ram_n=1; rdata/spi_addr/spi_wdata=0; timeout_err=0.
//   - last_grant=RAM, so ROM wins the first tie.
//   - Reset mid-transaction forces IDLE immediately; no ack is issued.
//  FSM: IDLE -> START -> BUSY -> ACK -> IDLE
//   IDLE
//    - Only one request high: grant it.
//    - Both high: grant the one not in last_grant (round-robin), then update last_grant.
//    - On grant, latch addr/we/wdata into spi_* regs and go to START.
//    - ROM grant always has spi_write=0.
//   START
//    - spi_start=1 for exactly this cycle; granted cs_*_n=0.
//    - spi_done is ignored here. Next state is BUSY; watchdog counter cleared.
//   BUSY
//    - Granted cs_*_n stays 0; counter increments each cycle.
//    - spi_done=1: capture rdata<=spi_rdata (reads only; rdata unchanged on writes).
//      Go to ACK.
//    - Counter reaches TIMEOUT-1 with no spi_done: rdata<=8'hFF, timeout_err<=1, go to ACK.
//   ACK
//    - Granted ack=1 for one cycle; both cs_*_n=1.
//    - Next state is IDLE; at most one SPI transaction in flight.
//  Latency and request handling
//   - Request seen in IDLE at cycle 0: START at 1, BUSY from 2.
//   - spi_done at cycle N gives ACK at N+1. Minimum 4 cycles request-to-ack.
//   - A request dropped mid-transaction does not cancel it; the ack is still issued.
//   - Requests are re-sampled only in IDLE. A request still high in the ACK cycle
//     is a new request.
//   - Never both cs low; never both acks in the same cycle.
// TESTING
//  1. rom_req=1, addr=16'h0012, spi_done 5 cyc after start, spi_rdata=8'hA5
//     -> one spi_start, cs_rom_n low START..BUSY, rom_ack 1 cyc, rdata=A5.
//  2. ram_req, we=1, addr=16'h0034, wdata=8'h5C
//     -> spi_write=1, spi_wdata=5C, cs_ram_n low, ram_ack pulse, rdata unchanged.
//  3. rom_req and ram_req held high together
//     -> grants alternate ROM,RAM,ROM,RAM; cs never both low.
//  4. ram read with spi_done never asserted, TIMEOUT=64
//     -> ram_ack 64 cyc after BUSY entry, rdata=FF, timeout_err=1 and stays 1.
//  5. rst pulsed during BUSY
//     -> IDLE next edge, both cs high, no ack, timeout_err=0; next request serviced normally.
//  6. spi_done high during START cycle
//     -> ignored; transaction completes on the next spi_done in BUSY.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the single SPI master between instruction fetch (ROM) and data
// access (RAM), sequencing start/busy/ack and guarding each transfer with a watchdog.
module spi_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_req,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ack,
  input  logic              ram_req,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_wdata,
  output logic              ram_ack,
  output logic [7:0]        rdata,
  output logic              spi_start,
  output logic              spi_write,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [7:0]        spi_wdata,
  input  logic [7:0]        spi_rdata,
  input  logic              spi_done,
  output logic              cs_rom_n,
  output logic              cs_ram_n,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             grant_ram;
  logic             last_grant_ram;
  logic [CNT_W-1:0] wd_cnt;
  logic             any_req;
  logic             pick_ram;
  logic             wd_expire;
  logic             in_xfer;

  assign any_req   = rom_req | ram_req;
  // RAM wins when alone, or on a tie when ROM held the previous grant.
  assign pick_ram  = ram_req & (~rom_req | ~last_grant_ram);
  assign wd_expire = (wd_cnt == CNT_LAST);
  assign in_xfer   = (state == S_START) || (state == S_BUSY);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_START;
      S_START: state_nxt = S_BUSY;
      S_BUSY:  if (spi_done || wd_expire) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      grant_ram      <= 1'b0;
      last_grant_ram <= 1'b1;
      spi_write      <= 1'b0;
      spi_addr       <= '0;
      spi_wdata      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) begin
        grant_ram      <= pick_ram;
        last_grant_ram <= pick_ram;
        if (pick_ram) begin
          spi_addr  <= ram_addr;
          spi_write <= ram_we;
          spi_wdata <= ram_wdata;
        end else begin
          spi_addr  <= rom_addr;
          spi_write <= 1'b0;
          spi_wdata <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_BUSY) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // A completion beats a simultaneous watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      timeout_err <= 1'b0;
    end else if (state == S_BUSY) begin
      if (spi_done) begin
        if (!spi_write) rdata <= spi_rdata;
      end else if (wd_expire) begin
        rdata       <= 8'hFF;
        timeout_err <= 1'b1;
      end
    end
  end

  assign spi_start = (state == S_START);
  assign cs_rom_n  = ~(in_xfer & ~grant_ram);
  assign cs_ram_n  = ~(in_xfer &  grant_ram);
  assign rom_ack   = (state == S_ACK) & ~grant_ram;
  assign ram_ack   = (state == S_ACK) &  grant_ram;

  a_cs_exclusive: assert property (@(posedge clk) disable iff (rst) !(!cs_rom_n && !cs_ram_n));
  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(rom_ack && ram_ack));

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a behavioural SPI responder answers each
// start, expected transactions are queued at request time and checked at start/ack.
module tb_spi_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic        ram_req;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_ack;
  logic [7:0]  rdata;
  logic        spi_start;
  logic        spi_write;
  logic [15:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic        spi_done;
  logic        cs_rom_n;
  logic        cs_ram_n;
  logic        timeout_err;

  spi_bus_arbiter #(.ADDR_W(16), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_ack     (ram_ack),
    .rdata       (rdata),
    .spi_start   (spi_start),
    .spi_write   (spi_write),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_rdata   (spi_rdata),
    .spi_done    (spi_done),
    .cs_rom_n    (cs_rom_n),
    .cs_ram_n    (cs_ram_n),
    .timeout_err (timeout_err)
  );

  typedef struct {
    bit          is_ram;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
  } item_t;

  item_t      exp_q[$];
  item_t      cur;
  bit         in_flight;
  int         start_cyc;
  int         cyc;
  int         n_checks;
  int         n_errors;
  int         resp_mode;   // 0 silent, 1 normal, 2 spurious done during START
  int         resp_delay;
  logic [7:0] model_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read data the responder returns for a given address.
  function automatic logic [7:0] slave_data(input logic [15:0] a);
    return a[7:0] ^ 8'hB7;
  endfunction

  task automatic exp_push(input bit is_ram, input bit we, input logic [15:0] addr,
                          input logic [7:0] wdata, input int lat, input bit tmo);
    item_t it;
    if (tmo) model_rdata = 8'hFF;
    else if (!we) model_rdata = slave_data(addr);
    it.is_ram = is_ram;
    it.we     = we;
    it.addr   = addr;
    it.wdata  = wdata;
    it.rdata  = model_rdata;
    it.lat    = lat;
    exp_q.push_back(it);
  endtask

  // Waits (bounded) for the requester's ack; returns negedges waited, ends just after the next posedge.
  task automatic wait_ack(input bit is_ram, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n = i + 1;
      if (is_ram ? ram_ack : rom_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(is_ram ? "ram_ack_wait" : "rom_ack_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // SPI responder
  initial begin
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && spi_start && resp_mode != 0) begin
        if (resp_mode == 2) begin
          spi_done  = 1'b1;
          spi_rdata = 8'h11;
          @(posedge clk);
          #1 spi_done = 1'b0;
          repeat (resp_delay - 1) @(posedge clk);
        end else begin
          repeat (resp_delay) @(posedge clk);
        end
        #1;
        spi_done  = 1'b1;
        spi_rdata = slave_data(spi_addr);
        @(posedge clk);
        #1;
        spi_done  = 1'b0;
        spi_rdata = 8'h00;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else if (rom_ack || ram_ack) begin
      if (!in_flight) begin
        check("ack_unexpected", 32'({rom_ack, ram_ack}), 32'd0);
      end else begin
        check("ack_sel", 32'({rom_ack, ram_ack}), cur.is_ram ? 32'd1 : 32'd2);
        check("rdata", 32'(rdata), 32'(cur.rdata));
        check("latency", 32'(cyc - start_cyc), 32'(cur.lat));
        check("cs_ack", 32'({cs_rom_n, cs_ram_n}), 32'd3);
        in_flight = 1'b0;
      end
    end else if (spi_start) begin
      if (in_flight || exp_q.size() == 0) begin
        check("start_unexpected", 32'(spi_start), 32'd0);
      end else begin
        cur       = exp_q.pop_front();
        in_flight = 1'b1;
        start_cyc = cyc;
        check("spi_write", 32'(spi_write), 32'(cur.we));
        check("spi_addr", 32'(spi_addr), 32'(cur.addr));
        if (cur.is_ram) check("spi_wdata", 32'(spi_wdata), 32'(cur.wdata));
        check("cs_start", 32'({cs_rom_n, cs_ram_n}), cur.is_ram ? 32'd2 : 32'd1);
      end
    end else if (in_flight) begin
      check("cs_busy", 32'({cs_rom_n, cs_ram_n}), cur.is_ram ? 32'd2 : 32'd1);
    end else begin
      check("cs_idle", 32'({cs_rom_n, cs_ram_n}), 32'd3);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  n;
    bit  seen;
    cyc         = 0;
    n_checks    = 0;
    n_errors    = 0;
    in_flight   = 1'b0;
    resp_mode   = 1;
    resp_delay  = 2;
    model_rdata = 8'h00;
    rst         = 1'b1;
    rom_req     = 1'b0;
    rom_addr    = '0;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    repeat (3) @(negedge clk);
    check("rst_cs", 32'({cs_rom_n, cs_ram_n}), 32'd3);
    check("rst_acks", 32'({rom_ack, ram_ack}), 32'd0);
    check("rst_start_write", 32'({spi_start, spi_write}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_spi_addr", 32'(spi_addr), 32'd0);
    check("rst_spi_wdata", 32'(spi_wdata), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Simultaneous requests: ROM, RAM, ROM, RAM
    resp_delay = 2;
    exp_push(1'b0, 1'b0, 16'h0100, 8'h00, 3, 1'b0);
    exp_push(1'b1, 1'b1, 16'h0201, 8'h3E, 3, 1'b0);
    exp_push(1'b0, 1'b0, 16'h0102, 8'h00, 3, 1'b0);
    exp_push(1'b1, 1'b0, 16'h0203, 8'h00, 3, 1'b0);
    fork
      begin
        int k;
        rom_addr = 16'h0100;
        rom_req  = 1'b1;
        wait_ack(1'b0, k);
        rom_addr = 16'h0102;
        wait_ack(1'b0, k);
        rom_req  = 1'b0;
      end
      begin
        int k;
        ram_addr  = 16'h0201;
        ram_we    = 1'b1;
        ram_wdata = 8'h3E;
        ram_req   = 1'b1;
        wait_ack(1'b1, k);
        ram_addr  = 16'h0203;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        wait_ack(1'b1, k);
        ram_req   = 1'b0;
      end
    join

    // ROM fetch, done 5 cycles after start
    resp_delay = 5;
    exp_push(1'b0, 1'b0, 16'h0012, 8'h00, 6, 1'b0);
    rom_addr = 16'h0012;
    rom_req  = 1'b1;
    wait_ack(1'b0, n);
    rom_req  = 1'b0;
    check("t1_rdata_held", 32'(rdata), 32'h0000_00A5);

    // RAM write leaves rdata unchanged
    resp_delay = 3;
    exp_push(1'b1, 1'b1, 16'h0034, 8'h5C, 4, 1'b0);
    ram_addr  = 16'h0034;
    ram_we    = 1'b1;
    ram_wdata = 8'h5C;
    ram_req   = 1'b1;
    wait_ack(1'b1, n);
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    check("t2_rdata_held", 32'(rdata), 32'h0000_00A5);

    // Fastest turnaround: done on the first BUSY cycle
    resp_delay = 1;
    exp_push(1'b1, 1'b0, 16'h0077, 8'h21, 2, 1'b0);
    ram_addr  = 16'h0077;
    ram_wdata = 8'h21;
    ram_req   = 1'b1;
    wait_ack(1'b1, n);
    ram_req   = 1'b0;
    check("min_req_to_ack", 32'(n), 32'd4);

    // Spurious done during START is ignored
    resp_mode  = 2;
    resp_delay = 3;
    exp_push(1'b0, 1'b0, 16'h0040, 8'h00, 4, 1'b0);
    rom_addr = 16'h0040;
    rom_req  = 1'b1;
    wait_ack(1'b0, n);
    rom_req  = 1'b0;

    // Watchdog abort on a RAM read
    resp_mode = 0;
    exp_push(1'b1, 1'b0, 16'h0055, 8'h00, 65, 1'b1);
    ram_addr  = 16'h0055;
    ram_wdata = 8'h00;
    ram_req   = 1'b1;
    wait_ack(1'b1, n);
    ram_req   = 1'b0;
    check("timeout_err_set", 32'(timeout_err), 32'd1);

    resp_mode  = 1;
    resp_delay = 2;
    exp_push(1'b0, 1'b0, 16'h0066, 8'h00, 3, 1'b0);
    rom_addr = 16'h0066;
    rom_req  = 1'b1;
    wait_ack(1'b0, n);
    rom_req  = 1'b0;
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during BUSY aborts without an ack
    resp_mode = 0;
    exp_push(1'b1, 1'b0, 16'h0088, 8'h00, 0, 1'b0);
    ram_addr = 16'h0088;
    ram_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_start_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    ram_req = 1'b0;
    @(negedge clk);
    check("t5_cs", 32'({cs_rom_n, cs_ram_n}), 32'd3);
    check("t5_acks", 32'({rom_ack, ram_ack}), 32'd0);
    check("t5_timeout_err", 32'(timeout_err), 32'd0);
    check("t5_rdata", 32'(rdata), 32'd0);
    #2 rst = 1'b0;
    model_rdata = 8'h00;

    resp_mode  = 1;
    resp_delay = 2;
    exp_push(1'b1, 1'b1, 16'h0099, 8'hC3, 3, 1'b0);
    ram_addr  = 16'h0099;
    ram_we    = 1'b1;
    ram_wdata = 8'hC3;
    ram_req   = 1'b1;
    wait_ack(1'b1, n);
    ram_req   = 1'b0;
    ram_we    = 1'b0;

    exp_push(1'b0, 1'b0, 16'h0012, 8'h00, 3, 1'b0);
    rom_addr = 16'h0012;
    rom_req  = 1'b1;
    wait_ack(1'b0, n);
    rom_req  = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_inflight", 32'(in_flight), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
